// File: rtl/rot_square_pkg.sv
// rot_square_pkg: segment codes, state/frame types and the frame decoder shared by the
// rotating-square display driver and its receive-side decoder.
package rot_square_pkg;
  localparam logic [6:0] UPPER_CODE = 7'b0011100;
  localparam logic [6:0] LOWER_CODE = 7'b1100010;
  typedef enum logic {ACQUIRE, TRACK} state_t;
  typedef enum logic [1:0] {VALID, BLANK, BAD} frame_class_t;
  typedef struct packed {
    frame_class_t cls;
    logic [2:0]   idx;
  } frame_t;
  function automatic frame_t decode_frame(input logic [3:0] an, input logic [6:0] sseg);
    frame_t f;
    logic [2:0] d;
    logic one_hot;
    d = an == 4'b0111 ? 3'd0 : an == 4'b1011 ? 3'd1 : an == 4'b1101 ? 3'd2 : 3'd3;
    one_hot = an == 4'b0111 || an == 4'b1011 || an == 4'b1101 || an == 4'b1110;
    // lower half runs right-to-left, so its index mirrors the digit number
    f.idx = sseg == UPPER_CODE ? d : 3'd7 - d;
    if (an == 4'b1111) f.cls = BLANK;
    else if (one_hot && (sseg == UPPER_CODE || sseg == LOWER_CODE)) f.cls = VALID;
    else f.cls = BAD;
    return f;
  endfunction
endpackage

// File: rtl/stable_filter.sv
// stable_filter: registers a bus and pulses acc_o once, with the value on q_o, when a value
// different from the last accepted one has held for STABLE_CYCLES clocks.
module stable_filter #(
  parameter int WIDTH         = 11,
  parameter int STABLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic             acc_o,
  output logic [WIDTH-1:0] q_o
);
  localparam logic [7:0] SC = 8'(STABLE_CYCLES);
  logic [WIDTH-1:0] s_q, q_q;
  logic [7:0] c_q, c_d;
  logic acc_q, hit;
  always_comb begin
    c_d = d_i != s_q ? 8'd1 : c_q == SC ? c_q : c_q + 8'd1;
    hit = c_d == SC && d_i != q_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q   <= '0;
      q_q   <= '0;
      c_q   <= '0;
      acc_q <= 1'b0;
    end else begin
      s_q   <= d_i;
      c_q   <= c_d;
      acc_q <= hit;
      if (hit) q_q <= d_i;
    end
  end
  assign acc_o = acc_q;
  assign q_o   = q_q;
endmodule

// File: rtl/rot_square_decoder.sv
// rot_square_decoder: monitors a multiplexed 4-digit seven-segment bus and recovers the rotating
// square's position, direction and step count. ROT_SQUARE_REV_COUNT_EN adds a revolution counter.
module rot_square_decoder
  import rot_square_pkg::*;
#(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 2**20,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       an,
  input  logic [6:0]       sseg,
  input  logic             err_clr,
  output logic [2:0]       pos,
  output logic             pos_valid,
  output logic             dir_cw,
  output logic             dir_valid,
  output logic             step,
  output logic [CNT_W-1:0] step_count,
  output logic             stalled,
`ifdef ROT_SQUARE_REV_COUNT_EN
  output logic [7:0]       rev_count,
`endif
  output logic             err_bad,
  output logic             err_jump
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO = TW'(TIMEOUT_CYCLES);
  logic acc;
  logic [10:0] frm;
  frame_t f;
  state_t state_q, state_d;
  logic [2:0] pos_q, pos_d;
  logic pv_q, pv_d, cw_q, cw_d, dv_q, dv_d, step_q, step_d;
  logic stall_q, stall_d, eb_q, eb_d, ej_q, ej_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic trk, valid, fwd, back, jump;

  stable_filter #(.WIDTH(11), .STABLE_CYCLES(STABLE_CYCLES)) u_filter (
    .clk   (clk),
    .rst_n (rst),
    .d_i   ({an, sseg}),
    .acc_o (acc),
    .q_o   (frm)
  );

  assign f = decode_frame(frm[10:7], frm[6:0]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ACQUIRE;
    else state_q <= state_d;
  end

  always_comb state_d = acc ? (f.cls == VALID ? TRACK : ACQUIRE) : state_q;

  always_comb begin
    trk     = state_q == TRACK;
    valid   = acc && f.cls == VALID;
    fwd     = f.idx == pos_q + 3'd1;
    back    = f.idx == pos_q - 3'd1;
    step_d  = valid && trk && (fwd || back);
    jump    = valid && trk && !(fwd || back);
    pos_d   = valid ? f.idx : pos_q;
    pv_d    = state_d == TRACK;
    cw_d    = step_d ? fwd : cw_q;
    dv_d    = step_d || (dv_q && !acc);
    cnt_d   = cnt_q + CNT_W'(step_d);
    eb_d    = (acc && f.cls == BAD) || (eb_q && !err_clr);
    ej_d    = jump || (ej_q && !err_clr);
    // timer restarts on every accepted frame; stalled latches until a real step or loss of lock
    tmr_d   = state_d != TRACK || acc ? '0 : tmr_q == TO ? tmr_q : tmr_q + 1'b1;
    stall_d = state_d == TRACK && !step_d && (stall_q || tmr_d == TO);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pos_q   <= '0;
      pv_q    <= 1'b0;
      cw_q    <= 1'b0;
      dv_q    <= 1'b0;
      step_q  <= 1'b0;
      cnt_q   <= '0;
      tmr_q   <= '0;
      stall_q <= 1'b0;
      eb_q    <= 1'b0;
      ej_q    <= 1'b0;
    end else begin
      pos_q   <= pos_d;
      pv_q    <= pv_d;
      cw_q    <= cw_d;
      dv_q    <= dv_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
      stall_q <= stall_d;
      eb_q    <= eb_d;
      ej_q    <= ej_d;
    end
  end

`ifdef ROT_SQUARE_REV_COUNT_EN
  logic [2:0] run_q, run_d;
  logic [7:0] rev_q, rev_d;
  logic same;
  always_comb begin
    same  = dv_q && cw_q == fwd;
    run_d = step_d ? (same ? run_q + 3'd1 : 3'd1) : acc ? 3'd0 : run_q;
    rev_d = rev_q + 8'(step_d && same && run_q == 3'd7);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_q <= '0;
      rev_q <= '0;
    end else begin
      run_q <= run_d;
      rev_q <= rev_d;
    end
  end
  assign rev_count = rev_q;
`endif

  assign pos        = pos_q;
  assign pos_valid  = pv_q;
  assign dir_cw     = cw_q;
  assign dir_valid  = dv_q;
  assign step       = step_q;
  assign step_count = cnt_q;
  assign stalled    = stall_q;
  assign err_bad    = eb_q;
  assign err_jump   = ej_q;
endmodule

// File: tb/tb_rot_square_decoder.sv
// tb_rot_square_decoder: randomized and directed checks of rot_square_decoder against a
// frame-level reference model.
module tb_rot_square_decoder;
  localparam int S  = 4;
  localparam int TO = 100;
  localparam logic [6:0] U = 7'b0011100;
  localparam logic [6:0] L = 7'b1100010;
  localparam logic [10:0] IDLE = {4'hf, 7'h7f};

  logic clk = 1'b0, rst = 1'b1, err_clr = 1'b0;
  logic [3:0] an = 4'hf;
  logic [6:0] sseg = 7'h7f;
  logic [2:0] pos;
  logic pos_valid, dir_cw, dir_valid, step, stalled, err_bad, err_jump;
  logic [15:0] step_count;
`ifdef ROT_SQUARE_REV_COUNT_EN
  logic [7:0] rev_count;
`endif

  rot_square_decoder #(.STABLE_CYCLES(S), .TIMEOUT_CYCLES(TO), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .an(an), .sseg(sseg), .err_clr(err_clr),
    .pos(pos), .pos_valid(pos_valid), .dir_cw(dir_cw), .dir_valid(dir_valid),
    .step(step), .step_count(step_count), .stalled(stalled),
`ifdef ROT_SQUARE_REV_COUNT_EN
    .rev_count(rev_count),
`endif
    .err_bad(err_bad), .err_jump(err_jump)
  );

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;
  logic [10:0] tbl [8];
  int m_pos, m_cnt, m_since, m_nsteps, m_run, m_rev, run_len, obs_steps;
  bit m_track, m_cw, m_dv, m_step, m_stall, m_eb, m_ej, pend_v;
  logic [10:0] pend_f, prev_in, last_acc;

  function automatic int find_idx(input logic [10:0] fr);
    for (int i = 0; i < 8; i++) if (tbl[i] == fr) return i;
    return -1;
  endfunction

  function automatic logic [25:0] expv();
    logic [2:0] p;
    logic [15:0] c;
    p = 3'(m_pos);
    c = 16'(m_cnt);
    return {p, m_track, m_cw, m_dv, m_step, c, m_stall, m_eb, m_ej};
  endfunction

  function automatic logic [25:0] outv();
    return {pos, pos_valid, dir_cw, dir_valid, step, step_count, stalled, err_bad, err_jump};
  endfunction

  task automatic model_reset();
    m_pos = 0; m_cnt = 0; m_since = 0; m_run = 0; m_rev = 0; run_len = 0;
    m_track = 0; m_cw = 0; m_dv = 0; m_step = 0; m_stall = 0; m_eb = 0; m_ej = 0;
    pend_v = 0; pend_f = '0; prev_in = '0; last_acc = '0;
  endtask

  // One clock edge of the reference: apply the frame accepted on the previous edge, then
  // decide whether the current input has just completed its stability window.
  task automatic model_edge();
    bit st, eb_ev, ej_ev;
    int idx, d;
    logic [10:0] in;
    st = 0; eb_ev = 0; ej_ev = 0;
    if (pend_v) begin
      idx = find_idx(pend_f);
      if (idx >= 0) begin
        if (!m_track) begin
          m_track = 1; m_dv = 0;
        end else begin
          d = (idx - m_pos + 8) % 8;
          if (d == 1 || d == 7) begin
            st = 1;
            if (m_dv && m_cw == (d == 1)) m_run++; else m_run = 1;
            if (m_run == 8) begin m_rev = (m_rev + 1) % 256; m_run = 0; end
            m_cw = (d == 1); m_dv = 1; m_cnt = (m_cnt + 1) % 65536; m_nsteps++;
          end else begin
            ej_ev = 1; m_dv = 0; m_run = 0;
          end
        end
        m_pos = idx;
      end else begin
        eb_ev = pend_f[10:7] != 4'hf;
        m_track = 0; m_dv = 0; m_run = 0;
      end
      m_since = 0;
    end else if (m_track) m_since++;
    if (!m_track || st) m_stall = 0;
    else if (m_since >= TO) m_stall = 1;
    m_eb = eb_ev || (m_eb && !err_clr);
    m_ej = ej_ev || (m_ej && !err_clr);
    m_step = st;
    in = {an, sseg};
    if (in == prev_in) run_len++; else run_len = 1;
    prev_in = in;
    pend_v = run_len == S && in != last_acc;
    if (pend_v) begin pend_f = in; last_acc = in; end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    if (step === 1'b1) obs_steps++;
  endtask

  task automatic hold(input logic [10:0] fr, input int n);
    {an, sseg} = fr;
    repeat (n) tick();
  endtask

  task automatic test_reset();
    {an, sseg} = IDLE;
    model_reset();
    #1 rst = 1'b0;
    #2;
    vectors++;
    if (outv() !== 26'h0) begin miscompares++; $display("FAIL reset_async got=%h exp=0", outv()); end
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (outv() !== expv()) begin miscompares++; $display("FAIL reset_hold got=%h exp=%h", outv(), expv()); end
    rst = 1'b1;
  endtask

  task automatic test_acquire();
    int first;
    hold(IDLE, 6);
    first = -1;
    {an, sseg} = tbl[0];
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (first < 0 && pos_valid === 1'b1) first = k;
    end
    vectors++;
    if (first != 5) begin miscompares++; $display("FAIL acquire_latency got=%0d exp=5", first); end
    vectors++;
    if ({pos, pos_valid, dir_valid, step_count} !== {3'd0, 1'b1, 1'b0, 16'd0}) begin
      miscompares++; $display("FAIL acquire_state got=%h exp=%h", {pos, pos_valid, dir_valid, step_count}, {3'd0, 1'b1, 1'b0, 16'd0});
    end
    vectors++;
    if (outv() !== expv()) begin miscompares++; $display("FAIL acquire_model got=%h exp=%h", outv(), expv()); end
  endtask

  task automatic test_cw_sweep();
    int base;
    base = obs_steps;
    for (int p = 1; p <= 8; p++) begin
      {an, sseg} = tbl[p % 8];
      for (int k = 1; k <= 6; k++) begin
        tick();
        if (p == 1) begin
          vectors++;
          if (step !== 1'(k == 5)) begin miscompares++; $display("FAIL cw_step_timing edge=%0d got=%b exp=%b", k, step, k == 5); end
        end
      end
    end
    vectors++;
    if (obs_steps - base != 8) begin miscompares++; $display("FAIL cw_pulses got=%0d exp=8", obs_steps - base); end
    vectors++;
    if ({pos, dir_cw, dir_valid, step_count} !== {3'd0, 1'b1, 1'b1, 16'd8}) begin
      miscompares++; $display("FAIL cw_final got=%h exp=%h", {pos, dir_cw, dir_valid, step_count}, {3'd0, 1'b1, 1'b1, 16'd8});
    end
    vectors++;
    if (outv() !== expv()) begin miscompares++; $display("FAIL cw_model got=%h exp=%h", outv(), expv()); end
  endtask

  task automatic test_ccw_glitch();
    int base;
    hold(tbl[1], 6);
    hold(tbl[2], 6);
    hold(tbl[3], 6);
    base = obs_steps;
    hold(tbl[2], 6);
    hold({4'b0000, U}, 2);
    hold(tbl[2], 6);
    vectors++;
    if (obs_steps - base != 1) begin miscompares++; $display("FAIL glitch_steps got=%0d exp=1", obs_steps - base); end
    hold(tbl[1], 6);
    vectors++;
    if ({pos, dir_cw, err_bad, err_jump, step_count} !== {3'd1, 1'b0, 1'b0, 1'b0, 16'd13}) begin
      miscompares++; $display("FAIL ccw_final got=%h exp=%h", {pos, dir_cw, err_bad, err_jump, step_count}, {3'd1, 1'b0, 1'b0, 1'b0, 16'd13});
    end
    vectors++;
    if (outv() !== expv()) begin miscompares++; $display("FAIL ccw_model got=%h exp=%h", outv(), expv()); end
  endtask

  task automatic test_jump();
    int base;
    base = obs_steps;
    hold(tbl[5], 6);
    vectors++;
    if ({pos, dir_valid, err_jump, 1'(obs_steps != base)} !== {3'd5, 1'b0, 1'b1, 1'b0}) begin
      miscompares++; $display("FAIL jump_state got=%h exp=%h", {pos, dir_valid, err_jump, 1'(obs_steps != base)}, {3'd5, 1'b0, 1'b1, 1'b0});
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    tick();
    vectors++;
    if (err_jump !== 1'b0) begin miscompares++; $display("FAIL jump_clear got=%b exp=0", err_jump); end
    vectors++;
    if (outv() !== expv()) begin miscompares++; $display("FAIL jump_model got=%h exp=%h", outv(), expv()); end
  endtask

  task automatic test_bad();
    hold({4'b0011, U}, 7);
    vectors++;
    if ({err_bad, pos_valid} !== 2'b10) begin miscompares++; $display("FAIL bad_state got=%b exp=10", {err_bad, pos_valid}); end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    hold({4'hf, L}, 7);
    vectors++;
    if (err_bad !== 1'b0) begin miscompares++; $display("FAIL blank_no_err got=%b exp=0", err_bad); end
    {an, sseg} = {4'b0011, L};
    repeat (4) tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    vectors++;
    if (err_bad !== 1'b1) begin miscompares++; $display("FAIL clr_collision got=%b exp=1", err_bad); end
    hold(tbl[4], 7);
    vectors++;
    if ({pos, pos_valid} !== {3'd4, 1'b1}) begin miscompares++; $display("FAIL relock got=%h exp=%h", {pos, pos_valid}, {3'd4, 1'b1}); end
    vectors++;
    if (outv() !== expv()) begin miscompares++; $display("FAIL bad_model got=%h exp=%h", outv(), expv()); end
  endtask

  task automatic test_stall();
    hold(tbl[3], 6);
    {an, sseg} = tbl[2];
    for (int k = 1; k <= 105; k++) begin
      tick();
      if (k == 104) begin
        vectors++;
        if (stalled !== 1'b0) begin miscompares++; $display("FAIL stall_early got=%b exp=0", stalled); end
      end
    end
    vectors++;
    if (stalled !== 1'b1) begin miscompares++; $display("FAIL stall_set got=%b exp=1", stalled); end
    vectors++;
    if (outv() !== expv()) begin miscompares++; $display("FAIL stall_model got=%h exp=%h", outv(), expv()); end
    hold(tbl[3], 6);
    vectors++;
    if ({stalled, pos} !== {1'b0, 3'd3}) begin miscompares++; $display("FAIL stall_clear got=%h exp=%h", {stalled, pos}, {1'b0, 3'd3}); end
  endtask

  task automatic test_random();
    bit rdir;
    int r, len;
    logic [10:0] fr;
    rdir = 1;
    for (int n = 0; n < 80; n++) begin
      r = int'($urandom % 10);
      len = int'($urandom_range(5, 9));
      if (r < 6) begin
        if ($urandom % 5 == 0) rdir = !rdir;
        fr = tbl[(m_pos + (rdir ? 1 : 7)) % 8];
      end else if (r == 6) fr = tbl[$urandom % 8];
      else if (r == 7) fr = {4'hf, 7'($urandom)};
      else if (r == 8) fr = {4'($urandom), 7'($urandom)};
      else begin
        fr = ($urandom % 2 == 0) ? tbl[$urandom % 8] : {4'($urandom), 7'($urandom)};
        len = int'($urandom_range(1, 3));
      end
      {an, sseg} = fr;
      err_clr = ($urandom % 8 == 0);
      tick();
      err_clr = 1'b0;
      repeat (len - 1) tick();
      vectors++;
      if (outv() !== expv()) begin miscompares++; $display("FAIL random_%0d got=%h exp=%h", n, outv(), expv()); end
    end
    vectors++;
    if (obs_steps != m_nsteps) begin miscompares++; $display("FAIL random_pulses got=%0d exp=%0d", obs_steps, m_nsteps); end
`ifdef ROT_SQUARE_REV_COUNT_EN
    vectors++;
    if (rev_count !== 8'(m_rev)) begin miscompares++; $display("FAIL rev_count got=%0d exp=%0d", rev_count, m_rev); end
`endif
  endtask

  task automatic test_async_reset();
    hold(tbl[0], 6);
    hold(tbl[1], 6);
    vectors++;
    if (outv() !== expv()) begin miscompares++; $display("FAIL pre_reset_model got=%h exp=%h", outv(), expv()); end
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    model_reset();
    vectors++;
    if (outv() !== 26'h0) begin miscompares++; $display("FAIL async_reset got=%h exp=0", outv()); end
`ifdef ROT_SQUARE_REV_COUNT_EN
    vectors++;
    if (rev_count !== 8'h0) begin miscompares++; $display("FAIL async_reset_rev got=%0d exp=0", rev_count); end
`endif
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) tbl[i] = {~(4'b1000 >> i), U};
    for (int i = 4; i < 8; i++) tbl[i] = {~(4'b0001 << (i - 4)), L};
    m_nsteps = 0;
    obs_steps = 0;
    test_reset();
    test_acquire();
    test_cw_sweep();
    test_ccw_glitch();
    test_jump();
    test_bad();
    test_stall();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
